// File: rtl/phrase_field_composer_if.sv
// Bus between the LCD fetch path and the phrase field composer.
// The master side drives the fetch address, template data, live fields and update requests.
interface phrase_field_composer_if #(
  parameter int unsigned NUM_FIELDS = 3,
  parameter int unsigned FIELD_W    = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned STATE_W    = 2
);
  logic [ADDR_W-1:0]             disp_addr;
  logic [7:0]                    template_char;
  logic [NUM_FIELDS*FIELD_W-1:0] field_data;
  logic [STATE_W-1:0]            state_flag;
  logic                          update;
  logic                          busy;
  logic                          ready;
  logic [NUM_FIELDS-1:0]         overflow;
  logic [7:0]                    char_out;

  modport master (
    output disp_addr, template_char, field_data, state_flag, update,
    input  busy, ready, overflow, char_out
  );

  modport slave (
    input  disp_addr, template_char, field_data, state_flag, update,
    output busy, ready, overflow, char_out
  );
endinterface

// File: rtl/phrase_field_composer.sv
// Overlays decimal-converted numeric fields and a state letter onto the template phrase stream.
// Fields are snapshotted, converted serially (shift-add-3) and committed atomically to a display bank.
module phrase_field_composer #(
  parameter int unsigned                   NUM_FIELDS  = 3,
  parameter int unsigned                   FIELD_W     = 8,
  parameter int unsigned                   DIGITS      = 3,
  parameter int unsigned                   ADDR_W      = 5,
  parameter logic [NUM_FIELDS*ADDR_W-1:0]  FIELD_POS   = {5'd28, 5'd19, 5'd3},
  parameter int unsigned                   STATE_POS   = 14,
  parameter int unsigned                   NUM_STATES  = 4,
  parameter logic [8*NUM_STATES-1:0]       STATE_CHARS = "ERWI",
  parameter bit                            BLANK_LEAD  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  phrase_field_composer_if.slave bus
);

  localparam int unsigned BCD_W   = DIGITS * 4;
  localparam int unsigned IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned CNT_W   = $clog2(FIELD_W + 1);
  localparam int unsigned STATE_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int unsigned DATA_W  = NUM_FIELDS * FIELD_W;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} state_t;

  state_t                  state, state_d;
  logic [IDX_W-1:0]        idx, idx_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [DATA_W-1:0]       snap, snap_d;
  logic [FIELD_W-1:0]      shreg, shreg_d;
  logic [BCD_W-1:0]        bcd, bcd_d, bcd_adj;
  logic                    ov_acc, ov_acc_d;
  logic [BCD_W-1:0]        wk_bcd [NUM_FIELDS];
  logic [BCD_W-1:0]        wk_bcd_d [NUM_FIELDS];
  logic [BCD_W-1:0]        dp_bcd [NUM_FIELDS];
  logic [BCD_W-1:0]        dp_bcd_d [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]   wk_ov, wk_ov_d;
  logic [NUM_FIELDS-1:0]   dp_ov, dp_ov_d;
  logic                    pending, pending_d;
  logic                    busy, busy_d;
  logic                    ready, ready_d;

  logic [ADDR_W-1:0]       addr_q;
  logic [STATE_W-1:0]      sflag_q;
  logic [7:0]              char_out;
  logic [7:0]              mux_c;
  logic [7:0]              state_c;
  logic                    found;
  int unsigned             a_u, p_u, dsel;
  logic [3:0]              dig;

  // Add-3 correction applied to every BCD digit before each shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd[d*4 +: 4] >= 4'd5) begin
        bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      snap    <= '0;
      shreg   <= '0;
      bcd     <= '0;
      ov_acc  <= 1'b0;
      wk_ov   <= '0;
      dp_ov   <= '0;
      pending <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
        wk_bcd[i] <= '0;
        dp_bcd[i] <= '0;
      end
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      snap    <= snap_d;
      shreg   <= shreg_d;
      bcd     <= bcd_d;
      ov_acc  <= ov_acc_d;
      wk_ov   <= wk_ov_d;
      dp_ov   <= dp_ov_d;
      pending <= pending_d;
      busy    <= busy_d;
      ready   <= ready_d;
      wk_bcd  <= wk_bcd_d;
      dp_bcd  <= dp_bcd_d;
    end
  end

  // Conversion sequencer: one LOAD/SHIFT*FIELD_W/STORE pass per field, then a single COMMIT
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    snap_d    = snap;
    shreg_d   = shreg;
    bcd_d     = bcd;
    ov_acc_d  = ov_acc;
    wk_bcd_d  = wk_bcd;
    wk_ov_d   = wk_ov;
    dp_bcd_d  = dp_bcd;
    dp_ov_d   = dp_ov;
    pending_d = pending;
    ready_d   = ready;

    // Requests arriving mid-run (including during COMMIT) coalesce into one re-run
    if (bus.update && (state != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.update) begin
          snap_d  = bus.field_data;
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shreg_d  = snap[32'(idx)*FIELD_W +: FIELD_W];
        bcd_d    = '0;
        ov_acc_d = 1'b0;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        bcd_d    = {bcd_adj[BCD_W-2:0], shreg[FIELD_W-1]};
        shreg_d  = {shreg[FIELD_W-2:0], 1'b0};
        ov_acc_d = ov_acc | bcd_adj[BCD_W-1];
        cnt_d    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(FIELD_W - 1)) begin
          state_d = STORE;
        end
      end
      STORE: begin
        wk_bcd_d[idx] = bcd;
        wk_ov_d[idx]  = ov_acc;
        if (idx == IDX_W'(NUM_FIELDS - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = LOAD;
        end
      end
      COMMIT: begin
        dp_bcd_d = wk_bcd;
        dp_ov_d  = wk_ov;
        ready_d  = 1'b1;
        if (pending || bus.update) begin
          pending_d = 1'b0;
          snap_d    = bus.field_data;
          idx_d     = '0;
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State letter lookup; out-of-range codes show '?'
  always_comb begin
    state_c = "?";
    for (int unsigned k = 0; k < NUM_STATES; k++) begin
      if (sflag_q == STATE_W'(k)) begin
        state_c = STATE_CHARS[k*8 +: 8];
      end
    end
  end

  // Character mux: lowest-index field window wins, then state letter, then template
  always_comb begin
    mux_c = bus.template_char;
    found = 1'b0;
    a_u   = 32'(addr_q);
    p_u   = 0;
    dsel  = 0;
    dig   = '0;
    if (a_u == STATE_POS) begin
      mux_c = state_c;
    end
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      p_u = 32'(FIELD_POS[i*ADDR_W +: ADDR_W]);
      if (!found && (a_u >= p_u) && ((a_u - p_u) < DIGITS)) begin
        found = 1'b1;
        dsel  = DIGITS - 1 - (a_u - p_u);
        dig   = dp_bcd[i][dsel*4 +: 4];
        if (!ready) begin
          mux_c = "-";
        end else if (dp_ov[i]) begin
          mux_c = "*";
        end else if (BLANK_LEAD && (dsel != 0) && ((dp_bcd[i] >> (dsel*4)) == '0)) begin
          mux_c = 8'h20;
        end else begin
          mux_c = {4'h3, dig};
        end
      end
    end
  end

  // Two-stage fetch pipeline, runs every cycle regardless of conversion activity
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      sflag_q  <= '0;
      char_out <= 8'h20;
    end else begin
      addr_q   <= bus.disp_addr;
      sflag_q  <= bus.state_flag;
      char_out <= mux_c;
    end
  end

  assign bus.busy     = busy;
  assign bus.ready    = ready;
  assign bus.overflow = dp_ov;
  assign bus.char_out = char_out;

endmodule

// File: doc/phrase_field_composer.md
Name: phrase_field_composer

Overview:
Character composer for the 32-position LCD line buffer. It overlays NUM_FIELDS decimal-converted numeric fields and one state letter onto the template phrase ROM stream. It replaces the fixed 2-digit tens/units overlay with a parametrised block:
- sequential binary-to-BCD conversion (shift-add-3)
- snapshot/commit double buffering, so the LCD never shows a half-updated field
- leading-blank suppression, overflow marking and an update handshake

It sits between the template phrase ROM and the LCD write controller.

Parameters:
NUM_FIELDS, 3, number of numeric fields
FIELD_W, 8, bits per binary field
DIGITS, 3, decimal characters per field
ADDR_W, 5, display address width (32 positions)
FIELD_POS, {5'd28,5'd19,5'd3}, packed NUM_FIELDS*ADDR_W start address (most-significant digit) per field, field 0 in LSBs
STATE_POS, 14, display address of state letter
NUM_STATES, 4, number of state codes
STATE_CHARS, "ERWI", packed 8*NUM_STATES, state code k uses byte k from the LSB end
BLANK_LEAD, 1, 1 = leading zeros shown as space (digit 0 of value 0 is always shown)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
disp_addr  in  ADDR_W  display position being fetched
template_char  in  8  template ROM data; valid one cycle after disp_addr
field_data  in  NUM_FIELDS*FIELD_W  live binary field values, field 0 in LSBs
state_flag  in  $clog2(NUM_STATES)  live state code
update  in  1  single-cycle request to snapshot and convert all fields
busy  out  1  conversion in progress
ready  out  1  display bank holds at least one committed conversion
overflow  out  NUM_FIELDS  per-field overflow from the last commit
char_out  out  8  composed character; 2-cycle latency from disp_addr

Behaviour:
- Reset values: busy=0, ready=0, overflow=0, char_out=8'h20, pending=0, FSM=IDLE, display bank cleared.
- Reset is asynchronous and may assert in any state, including mid-conversion. It clears everything, including any pending request.
- Pipeline:
  - Stage 1 registers disp_addr into addr_q.
  - Stage 2 registers the mux result into char_out, using addr_q and the template_char arriving that cycle.
  - Latency from disp_addr to char_out is exactly 2 cycles, and the pipeline runs every cycle regardless of busy.
- Mux priority, evaluated on addr_q:
  1. Lowest-index field whose window [FIELD_POS[i], FIELD_POS[i]+DIGITS-1] contains addr_q.
  2. STATE_POS.
  3. template_char.
- Field character when ready=0: "-".
- Field character when ready=1:
  - overflow[i]=1: "*" in every position.
  - otherwise: ASCII digit, with leading zeros replaced by 8'h20 when BLANK_LEAD=1.
- State character: byte state_flag of STATE_CHARS, or "?" if state_flag>=NUM_STATES. state_flag is sampled live in stage 1.
- FSM states: IDLE, LOAD, SHIFT, STORE, COMMIT.
  - IDLE: update=1 snapshots field_data into the snapshot register, sets idx=0 and goes to LOAD. busy rises the next cycle.
  - LOAD (1 cycle): loads snapshot field idx into the shift register and clears the BCD accumulator.
  - SHIFT (FIELD_W cycles): each cycle adds 3 to every BCD digit >=5, then shifts left by 1. A 1 shifted out of the top digit sets that field's overflow bit in the work bank.
  - STORE (1 cycle): writes digits and the overflow bit into the work bank at idx. If idx==NUM_FIELDS-1 go to COMMIT, else idx++ and go to LOAD.
  - COMMIT (1 cycle): copies the work bank into the display bank in a single cycle and sets ready=1. If pending, clears pending, re-snapshots field_data and goes to LOAD; else goes to IDLE.
- busy=1 in every state except IDLE. One run with defaults lasts NUM_FIELDS*(FIELD_W+2)+1 = 31 cycles.
- update while busy sets pending. Any number of such requests coalesce into one re-run. busy stays high continuously across the re-run.
- update in the same cycle as COMMIT counts as pending.
- A field_data change after the snapshot has no effect on the current run.
- The display bank changes only in COMMIT.

Test Plan:
- Reset, then sweep disp_addr 0..31 -> char_out follows template_char 2 cycles later; addr 3..5, 19..21 and 28..30 give "---"; addr 14 gives the state letter; ready=0.
- field_data={255,42,7}, pulse update -> busy high 31 cycles; ready=1 after COMMIT; addr 3..5 = "  7", 19..21 = " 42", 28..30 = "255"; overflow=0.
- Change field_data to 0 at cycle 5 of a run -> displays still match the snapshot values after commit, and previous values before commit.
- Pulse update 3 times during a run -> exactly one re-run; busy stays high 62 contiguous cycles; final display shows the field_data present at the first COMMIT.
- state_flag 0..3 and 7 (with a 3-bit flag instance) at addr 14 -> "I","W","R","E","?".
- DIGITS=2 instance with field 0 = 123 -> overflow[0]=1 and "**".
- Reset asserted at run cycle 10 -> busy=0, ready=0, char_out=8'h20 and fields show "-"; no commit occurs afterwards.
